// File: rtl/fmul_share_arbiter.sv
// Round-robin front end sharing one fixed-latency FP32 multiplier between N_REQ requesters.
// Tags every issued op and returns the product with its requester ID; a refused response freezes the pipe.
module fmul_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT   = 3,
    parameter int DW    = 32,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DW-1:0]       req_a,
    input  logic [N_REQ*DW-1:0]       req_b,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      mul_clken,
    output logic [DW-1:0]             mul_a,
    output logic [DW-1:0]             mul_b,
    input  logic [DW-1:0]             mul_result,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [DW-1:0]             rsp_data,
    input  logic                      rsp_ready,
    output logic                      busy,
    output logic [$clog2(LAT+3)-1:0]  inflight
);

    localparam int IFW = $clog2(LAT+3);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [DW-1:0]  mul_a_q, mul_b_q;
    logic           tag_v_q  [LAT+1];
    logic [IDW-1:0] tag_id_q [LAT+1];
    logic [IFW-1:0] inflight_q, inflight_d;

    logic           adv;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic [N_REQ-1:0] grant_oh;
    logic           rsp_hs;

    assign rsp_valid = tag_v_q[LAT];
    assign rsp_id    = tag_id_q[LAT];
    assign rsp_data  = mul_result;
    assign adv       = !(rsp_valid && !rsp_ready);
    assign mul_clken = adv;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign busy      = (inflight_q != '0);
    assign inflight  = inflight_q;
    assign req_ready = grant_oh;

    // Scan starts at ptr and wraps; grant is also suppressed while reset is held.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        gnt_any  = 1'b0;
        gnt_id   = '0;
        grant_oh = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!gnt_any && req_valid[IDW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
        if (!adv || !reset) begin
            gnt_any = 1'b0;
            gnt_id  = '0;
        end
        if (gnt_any) grant_oh[gnt_id] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + IDW'(1);
    end

    always_comb begin
        inflight_d = inflight_q;
        if (gnt_any && !rsp_hs)      inflight_d = inflight_q + IFW'(1);
        else if (!gnt_any && rsp_hs) inflight_d = inflight_q - IFW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            inflight_q <= '0;
            for (int unsigned k = 0; k <= LAT; k++) begin
                tag_v_q[k]  <= 1'b0;
                tag_id_q[k] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            if (adv) begin
                ptr_q       <= ptr_d;
                tag_v_q[0]  <= gnt_any;
                tag_id_q[0] <= gnt_id;
                for (int unsigned k = 1; k <= LAT; k++) begin
                    tag_v_q[k]  <= tag_v_q[k-1];
                    tag_id_q[k] <= tag_id_q[k-1];
                end
                if (gnt_any) begin
                    mul_a_q <= req_a[32'(gnt_id)*DW +: DW];
                    mul_b_q <= req_b[32'(gnt_id)*DW +: DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Directed bench for fmul_share_arbiter with a behavioural LAT-stage multiplier model.
module tb_fmul_share_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int DW  = 32;

    localparam logic [31:0] F1P0  = 32'h3F80_0000;
    localparam logic [31:0] F1P5  = 32'h3FC0_0000;
    localparam logic [31:0] F2P0  = 32'h4000_0000;
    localparam logic [31:0] F3P0  = 32'h4040_0000;
    localparam logic [31:0] F6P0  = 32'h40C0_0000;
    localparam logic [31:0] FM2P0 = 32'hC000_0000;
    localparam logic [31:0] FM3P0 = 32'hC040_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_a, req_b;
    logic [N-1:0]    req_ready;
    logic            mul_clken;
    logic [DW-1:0]   mul_a, mul_b, mul_result;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_ready;
    logic            busy;
    logic [2:0]      inflight;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    fmul_share_arbiter #(.N_REQ(N), .LAT(LAT), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_clken(mul_clken), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy), .inflight(inflight)
    );

    // Stand-in multiplier: exact for 1.0*x and the few hand-computed pairs used below.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (a == F1P0) return b;
        if (a == F2P0 && b == F3P0)  return F6P0;
        if (a == F1P5 && b == FM2P0) return FM3P0;
        return 32'hFFFF_FFFF;
    endfunction

    logic [31:0] mp [LAT];
    always_ff @(posedge clk) begin
        if (mul_clken) begin
            mp[0] <= fmul(mul_a, mul_b);
            for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
        end
    end
    assign mul_result = mp[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    initial begin
        logic [31:0] bv [8];
        int exp_inf;

        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #1 reset = 1'b0;
        req_valid = 4'hF;
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_clken", 32'(mul_clken), 1);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_mul_a", mul_a, 0);
        req_valid = '0;
        reset = 1'b1;

        // All four requesters valid continuously from ptr=0
        for (int i = 0; i < N; i++) begin
            bv[i] = 32'h4100_0000 + 32'(i) * 32'h0010_0000;
            set_op(i, F1P0, bv[i]);
        end
        tick();
        req_valid = 4'hF;
        #1;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1) << (k % 4));
            if (k >= 4) begin
                chk($sformatf("rr_rsp_v%0d", k), 32'(rsp_valid), 1);
                chk($sformatf("rr_rsp_id%0d", k), 32'(rsp_id), 32'((k - 4) % 4));
                chk($sformatf("rr_rsp_d%0d", k), rsp_data, bv[(k - 4) % 4]);
            end
            if (k >= 4 && k < 8) chk($sformatf("rr_inflight%0d", k), 32'(inflight), 4);
            tick();
            if (k == 7) req_valid = '0;
            #1;
        end
        chk("rr_drained", 32'(inflight), 0);

        // Single op from requester 2, ptr=0
        set_op(2, F2P0, F3P0);
        req_valid = 4'b0100;
        #1;
        chk("single_grant", 32'(req_ready), 32'b0100);
        tick(); req_valid = '0; #1;
        chk("single_ready_drop", 32'(req_ready), 0);
        chk("single_inflight1", 32'(inflight), 1);
        chk("single_mul_a", mul_a, F2P0);
        chk("single_mul_b", mul_b, F3P0);
        for (int k = 2; k <= 3; k++) begin
            tick(); #1;
            chk($sformatf("single_early%0d", k), 32'(rsp_valid), 0);
        end
        tick(); #1;
        chk("single_rsp_v", 32'(rsp_valid), 1);
        chk("single_rsp_id", 32'(rsp_id), 2);
        chk("single_rsp_d", rsp_data, F6P0);
        tick(); #1;
        chk("single_rsp_gone", 32'(rsp_valid), 0);
        chk("single_inflight0", 32'(inflight), 0);
        chk("single_busy0", 32'(busy), 0);

        // Wrap/fairness: ptr=3, requesters 3 and 0 valid
        set_op(0, F1P0, 32'h4100_0000);
        set_op(3, F1P0, 32'h4110_0000);
        req_valid = 4'b1001;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) chk($sformatf("wrap_grant%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'b1000 : 32'b0001);
            if (k >= 4) begin
                chk($sformatf("wrap_rsp_id%0d", k), 32'(rsp_id), (k % 2 == 0) ? 3 : 0);
                chk($sformatf("wrap_rsp_d%0d", k), rsp_data, (k % 2 == 0) ? 32'h4110_0000 : 32'h4100_0000);
            end
            tick();
            if (k == 3) req_valid = '0;
            #1;
        end
        chk("wrap_drained", 32'(inflight), 0);

        // Backpressure with three ops in flight (ptr=1 -> grants 1,2,0)
        set_op(0, F1P0, 32'h4100_0000);
        set_op(1, F1P5, FM2P0);
        set_op(2, F2P0, F3P0);
        req_valid = 4'b0111;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'b0010);
        tick(); #1;
        chk("bp_grant1", 32'(req_ready), 32'b0100);
        tick(); #1;
        chk("bp_grant2", 32'(req_ready), 32'b0001);
        tick(); req_valid = '0; rsp_ready = 1'b0; #1;
        chk("bp_inflight3", 32'(inflight), 3);
        tick(); req_valid = 4'hF; #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_stall_v%0d", k), 32'(rsp_valid), 1);
            chk($sformatf("bp_stall_id%0d", k), 32'(rsp_id), 1);
            chk($sformatf("bp_stall_d%0d", k), rsp_data, FM3P0);
            chk($sformatf("bp_stall_clken%0d", k), 32'(mul_clken), 0);
            chk($sformatf("bp_stall_ready%0d", k), 32'(req_ready), 0);
            chk($sformatf("bp_stall_inf%0d", k), 32'(inflight), 3);
            if (k < 4) tick();
            #1;
        end
        req_valid = '0; rsp_ready = 1'b1; #1;
        chk("bp_release_clken", 32'(mul_clken), 1);
        chk("bp_drain_id0", 32'(rsp_id), 1);
        chk("bp_drain_d0", rsp_data, FM3P0);
        tick(); #1;
        chk("bp_drain_v1", 32'(rsp_valid), 1);
        chk("bp_drain_id1", 32'(rsp_id), 2);
        chk("bp_drain_d1", rsp_data, F6P0);
        tick(); #1;
        chk("bp_drain_v2", 32'(rsp_valid), 1);
        chk("bp_drain_id2", 32'(rsp_id), 0);
        chk("bp_drain_d2", rsp_data, 32'h4100_0000);
        tick(); #1;
        chk("bp_drained_v", 32'(rsp_valid), 0);
        chk("bp_drained_inf", 32'(inflight), 0);

        // Reset mid-operation with three ops in flight and one response showing
        set_op(1, F1P0, 32'h4200_0000);
        req_valid = 4'b0010;
        tick(); tick(); tick(); req_valid = '0; #1;
        chk("mr_inflight3", 32'(inflight), 3);
        tick(); #1;
        chk("mr_rsp_before", 32'(rsp_valid), 1);
        reset = 1'b0; #1;
        chk("mr_rsp_cleared", 32'(rsp_valid), 0);
        chk("mr_inflight_cleared", 32'(inflight), 0);
        chk("mr_busy_cleared", 32'(busy), 0);
        tick(); #1;
        reset = 1'b1; #1;
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            chk($sformatf("mr_no_stale%0d", k), 32'(rsp_valid), 0);
        end
        set_op(1, F2P0, F3P0);
        req_valid = 4'b0010; #1;
        chk("mr_new_grant", 32'(req_ready), 32'b0010);
        tick(); req_valid = '0; #1;
        tick(); tick(); tick(); #1;
        chk("mr_new_v", 32'(rsp_valid), 1);
        chk("mr_new_id", 32'(rsp_id), 1);
        chk("mr_new_d", rsp_data, F6P0);
        tick(); #1;

        // Single requester back-to-back for six cycles
        for (int i = 0; i < 6; i++) bv[i] = 32'h4300_0000 + 32'(i);
        set_op(1, F1P0, bv[0]);
        req_valid = 4'b0010; #1;
        for (int k = 0; k <= 10; k++) begin
            exp_inf = ((k < 6) ? k : 6) - ((k - 4 < 0) ? 0 : ((k - 4 > 6) ? 6 : k - 4));
            chk($sformatf("b2b_inflight%0d", k), 32'(inflight), 32'(exp_inf));
            if (k < 6) chk($sformatf("b2b_grant%0d", k), 32'(req_ready), 32'b0010);
            if (k >= 4 && k < 10) begin
                chk($sformatf("b2b_rsp_v%0d", k), 32'(rsp_valid), 1);
                chk($sformatf("b2b_rsp_id%0d", k), 32'(rsp_id), 1);
                chk($sformatf("b2b_rsp_d%0d", k), rsp_data, bv[k - 4]);
            end else if (k >= 10) begin
                chk("b2b_rsp_end", 32'(rsp_valid), 0);
            end
            tick();
            if (k < 5) set_op(1, F1P0, bv[k + 1]);
            else req_valid = '0;
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
